// File: rtl/rr_data_selector.sv
// rr_data_selector
//   Round-robin arbiter feeding one registered output slice. SEL_WIDTH
//   requesters, each with a valid/ready handshake, compete for a single
//   downstream port. One winner is accepted per cycle while the output
//   slice can load. The winner's payload and index are registered.
//
// Ports
//   clk             clock, rising edge
//   rst             asynchronous active-high reset
//   sel_in          per-channel request valid
//   data_in         per-channel payload (unpacked array)
//   sel_ready       one-hot accept toward the requesters
//   data_out        registered payload
//   data_out_valid  registered valid
//   data_out_ready  downstream accept
//   grant_idx       registered index of the channel that produced data_out
//   grant_cnt       per-channel saturating grant counters
//                   (present only with DATA_SELECTOR_PERF_EN)
//
// Build option
//   DATA_SELECTOR_PERF_EN  adds the grant_cnt port and its counters.
module rr_data_selector #(
    parameter int SEL_WIDTH  = 5,
    parameter int DATA_WIDTH = 5,
    parameter int CNT_WIDTH  = 16,
    localparam int IDX_W     = (SEL_WIDTH > 1) ? $clog2(SEL_WIDTH) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [SEL_WIDTH-1:0]  sel_in,
    input  logic [DATA_WIDTH-1:0] data_in [0:SEL_WIDTH-1],
    output logic [SEL_WIDTH-1:0]  sel_ready,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_out_valid,
    input  logic                  data_out_ready,
    output logic [IDX_W-1:0]      grant_idx
`ifdef DATA_SELECTOR_PERF_EN
    ,
    output logic [CNT_WIDTH-1:0]  grant_cnt [0:SEL_WIDTH-1]
`endif
);

    logic [IDX_W-1:0]      r_ptr;
    logic [IDX_W-1:0]      r_grant_idx;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_valid;

    logic                  w_load;
    logic                  w_any;
    logic                  w_take;
    logic [IDX_W-1:0]      w_win;
    logic [IDX_W-1:0]      w_hi_idx;
    logic [IDX_W-1:0]      w_lo_idx;
    logic                  w_hi_found;
    logic [IDX_W-1:0]      w_ptr_next;

    // Single slice, no skid buffer: load only when empty or draining.
    assign w_load = !r_valid || data_out_ready;
    assign w_any  = |sel_in;
    assign w_take = w_load && w_any;

    // Scanning downward leaves the lowest matching index in each half:
    // the "hi" half is indices at or above the pointer, "lo" wraps below.
    always_comb begin
        w_hi_idx   = '0;
        w_lo_idx   = '0;
        w_hi_found = 1'b0;
        for (int i = SEL_WIDTH - 1; i >= 0; i--) begin
            if (sel_in[i]) begin
                if (i >= int'(r_ptr)) begin
                    w_hi_idx   = IDX_W'(i);
                    w_hi_found = 1'b1;
                end else begin
                    w_lo_idx = IDX_W'(i);
                end
            end
        end
        w_win = w_hi_found ? w_hi_idx : w_lo_idx;
    end

    assign w_ptr_next = (int'(w_win) == SEL_WIDTH - 1) ? '0 : w_win + 1'b1;

    // Gated by rst so an accept is never reported while in reset.
    always_comb begin
        sel_ready = '0;
        if (w_take && !rst) begin
            sel_ready[w_win] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_grant_idx <= '0;
            r_ptr       <= '0;
        end else if (w_load) begin
            if (w_any) begin
                r_data      <= data_in[w_win];
                r_valid     <= 1'b1;
                r_grant_idx <= w_win;
                r_ptr       <= w_ptr_next;
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    assign data_out       = r_data;
    assign data_out_valid = r_valid;
    assign grant_idx      = r_grant_idx;

`ifdef DATA_SELECTOR_PERF_EN
    logic [CNT_WIDTH-1:0] r_cnt [0:SEL_WIDTH-1];

    // Saturating: a counter at all-ones holds rather than wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < SEL_WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < SEL_WIDTH; i++) begin
                if (sel_ready[i] && sel_in[i] && (r_cnt[i] != '1)) begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign grant_cnt = r_cnt;
`endif

endmodule
